csr_access_unit: RTL and testbench

//  Requester side of csr_intf: executes one Zicsr instruction at a time
//  (CSRRW/RS/RC and immediate forms). Reads the old CSR value, computes the
//  new value, issues the CSR write, returns the old value for rd.

---
 rtl/csr_access_unit.sv | 95 +++++++++
 tb/tb_csr_access_unit.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/csr_access_unit.sv
// csr_access_unit: executes one Zicsr instruction at a time against the CSR file.
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   i_flush                        abort any in-flight op, block acceptance
//   i_req_valid / o_req_ready      request handshake (ready only in IDLE)
//   i_req_funct3, i_req_addr       Zicsr funct3 and CSR address
//   i_req_rs1_data, i_req_rs1_idx  rs1 value, rs1 index (zimm for imm forms)
//   o_resp_valid / i_resp_ready    response handshake
//   o_resp_rdata, o_resp_illegal   old CSR value for rd, illegal indication
//   o_csr_ra, i_csr_rd             CSR read address, combinational read data
//   o_csr_valid, o_csr_wa, o_csr_wd one-cycle CSR write strobe, address, data
module csr_access_unit #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_flush,
    input  logic            i_req_valid,
    output logic            o_req_ready,
    input  logic [2:0]      i_req_funct3,
    input  logic [11:0]     i_req_addr,
    input  logic [XLEN-1:0] i_req_rs1_data,
    input  logic [4:0]      i_req_rs1_idx,
    output logic            o_resp_valid,
    input  logic            i_resp_ready,
    output logic [XLEN-1:0] o_resp_rdata,
    output logic            o_resp_illegal,
    output logic [11:0]     o_csr_ra,
    input  logic [XLEN-1:0] i_csr_rd,
    output logic            o_csr_valid,
    output logic [11:0]     o_csr_wa,
    output logic [XLEN-1:0] o_csr_wd
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
    state_t            r_state, w_next;
    logic [2:0]        r_funct3;
    logic [11:0]       r_addr;
    logic [XLEN-1:0]   r_opnd, r_new, r_rdata;
    logic              r_nz, r_wen, r_illegal;
    logic              w_accept, w_wen, w_known, w_illegal;
    logic [XLEN-1:0]   w_new;
    assign o_req_ready = (r_state == IDLE) & ~reset & ~i_flush;
    assign w_accept    = o_req_ready & i_req_valid;
    // funct3[1:0]: 01 RW, 10 RS, 11 RC; 00 is not a CSR op
    assign w_wen     = (r_funct3[1:0] == 2'b01) | r_nz;
    assign w_known   = r_addr inside {12'h300, 12'h304, 12'h305, 12'h340, 12'h341,
                                      12'h342, 12'h343, 12'h344, 12'hB00};
    assign w_illegal = (r_funct3[1:0] == 2'b00) | ~w_known | ((r_addr[11:10] == 2'b11) & w_wen);
    assign w_new     = (r_funct3[1:0] == 2'b01) ? r_opnd :
                       (r_funct3[1:0] == 2'b10) ? (i_csr_rd | r_opnd) : (i_csr_rd & ~r_opnd);
    assign o_csr_ra       = r_addr;
    assign o_csr_wa       = r_addr;
    assign o_csr_wd       = r_new;
    assign o_csr_valid    = (r_state == WRITE) & r_wen & ~r_illegal & ~i_flush & ~reset;
    assign o_resp_valid   = (r_state == RESP);
    assign o_resp_rdata   = r_rdata;
    assign o_resp_illegal = r_illegal;
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_accept ? READ : IDLE;
            READ:    w_next = WRITE;
            WRITE:   w_next = RESP;
            default: w_next = i_resp_ready ? IDLE : RESP;
        endcase
        if (i_flush) w_next = IDLE;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_funct3  <= '0;
            r_addr    <= '0;
            r_opnd    <= '0;
            r_nz      <= 1'b0;
            r_new     <= '0;
            r_rdata   <= '0;
            r_wen     <= 1'b0;
            r_illegal <= 1'b0;
        end else if (w_accept) begin
            r_funct3 <= i_req_funct3;
            r_addr   <= i_req_addr;
            // immediate forms use the zero-extended rs1 index as the operand
            r_opnd   <= i_req_funct3[2] ? XLEN'(i_req_rs1_idx) : i_req_rs1_data;
            r_nz     <= (i_req_rs1_idx != 5'd0);
        end else if (r_state == READ) begin
            r_new     <= w_new;
            r_wen     <= w_wen;
            r_illegal <= w_illegal;
            r_rdata   <= w_illegal ? '0 : i_csr_rd;
        end
    end
endmodule

// File: tb/tb_csr_access_unit.sv
// tb_csr_access_unit: table-driven and sequence checks for csr_access_unit.
module tb_csr_access_unit;
    logic        clk = 1'b0;
    logic        reset, i_flush, i_req_valid, o_req_ready, o_resp_valid, i_resp_ready;
    logic [2:0]  i_req_funct3;
    logic [11:0] i_req_addr, o_csr_ra, o_csr_wa;
    logic [63:0] i_req_rs1_data, o_resp_rdata, i_csr_rd, o_csr_wd;
    logic [4:0]  i_req_rs1_idx;
    logic        o_resp_illegal, o_csr_valid;
    logic [63:0] csr_mem [0:4095];
    int          checks = 0, failures = 0;
    always #5 clk = ~clk;
    assign i_csr_rd = csr_mem[o_csr_ra];
    csr_access_unit #(.XLEN(64)) dut (
        .clk(clk), .reset(reset), .i_flush(i_flush),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_funct3(i_req_funct3), .i_req_addr(i_req_addr),
        .i_req_rs1_data(i_req_rs1_data), .i_req_rs1_idx(i_req_rs1_idx),
        .o_resp_valid(o_resp_valid), .i_resp_ready(i_resp_ready),
        .o_resp_rdata(o_resp_rdata), .o_resp_illegal(o_resp_illegal),
        .o_csr_ra(o_csr_ra), .i_csr_rd(i_csr_rd),
        .o_csr_valid(o_csr_valid), .o_csr_wa(o_csr_wa), .o_csr_wd(o_csr_wd)
    );
    typedef struct {
        logic [2:0]  f3;
        logic [11:0] addr;
        logic [63:0] rs1;
        logic [4:0]  idx;
        logic [63:0] init;
        logic        wr;
        logic [63:0] wd;
        logic [63:0] rdata;
        logic        ill;
    } vec_t;
    vec_t vecs [12];
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    // drive a request at a negedge and wait (bounded) for it to be accepted
    task automatic issue(input logic [2:0] f3, input logic [11:0] addr,
                         input logic [63:0] rs1, input logic [4:0] idx, output bit ok);
        @(negedge clk);
        i_req_valid = 1'b1; i_req_funct3 = f3; i_req_addr = addr;
        i_req_rs1_data = rs1; i_req_rs1_idx = idx;
        ok = 1'b0;
        for (int k = 0; k < 10 && !ok; k++) begin
            #1;
            if (o_req_ready) ok = 1'b1;
            else @(negedge clk);
        end
        if (!ok) chk("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        @(negedge clk);
        i_req_valid = 1'b0;
    endtask
    initial begin
        bit ok;
        int wcyc, rcyc;
        logic [63:0] wd, rdata;
        logic [11:0] wa;
        logic        ill;
        for (int a = 0; a < 4096; a++) csr_mem[a] = '0;
        vecs[0]  = '{3'b001, 12'h340, 64'hA5, 5'd5, 64'h5, 1'b1, 64'hA5, 64'h5, 1'b0};
        vecs[1]  = '{3'b010, 12'h300, 64'hFF, 5'd0, 64'h8, 1'b0, 64'h0, 64'h8, 1'b0};
        vecs[2]  = '{3'b111, 12'h300, 64'h0, 5'd8, 64'h8, 1'b1, 64'h0, 64'h8, 1'b0};
        vecs[3]  = '{3'b010, 12'h304, 64'hF0, 5'd3, 64'h0F, 1'b1, 64'hFF, 64'h0F, 1'b0};
        vecs[4]  = '{3'b011, 12'h305, 64'hFF00, 5'd7, 64'h1234, 1'b1, 64'h0034, 64'h1234, 1'b0};
        vecs[5]  = '{3'b101, 12'h341, 64'hDEAD, 5'd0, 64'h77, 1'b1, 64'h0, 64'h77, 1'b0};
        vecs[6]  = '{3'b110, 12'h342, 64'h0, 5'd31, 64'h100, 1'b1, 64'h11F, 64'h100, 1'b0};
        vecs[7]  = '{3'b001, 12'h7C0, 64'h1, 5'd1, 64'h99, 1'b0, 64'h0, 64'h0, 1'b1};
        vecs[8]  = '{3'b100, 12'h340, 64'h1, 5'd1, 64'h42, 1'b0, 64'h0, 64'h0, 1'b1};
        vecs[9]  = '{3'b000, 12'h343, 64'h1, 5'd2, 64'h42, 1'b0, 64'h0, 64'h0, 1'b1};
        vecs[10] = '{3'b010, 12'hB00, 64'h0, 5'd0, 64'h123456789ABCDEF0, 1'b0, 64'h0, 64'h123456789ABCDEF0, 1'b0};
        vecs[11] = '{3'b011, 12'h344, 64'hFFFFFFFF00000000, 5'd9, 64'hFFFFFFFFFFFFFFFF, 1'b1, 64'h00000000FFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0};
        reset = 1'b1; i_flush = 1'b0; i_req_valid = 1'b0; i_resp_ready = 1'b1;
        i_req_funct3 = '0; i_req_addr = '0; i_req_rs1_data = '0; i_req_rs1_idx = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req_ready", 64'(o_req_ready), 64'd0);
        chk("rst_resp_valid", 64'(o_resp_valid), 64'd0);
        chk("rst_csr_valid", 64'(o_csr_valid), 64'd0);
        chk("rst_rdata", o_resp_rdata, 64'd0);
        chk("rst_wd", o_csr_wd, 64'd0);
        chk("rst_wa_ra", {40'd0, o_csr_wa, o_csr_ra}, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        #1;
        chk("idle_req_ready", 64'(o_req_ready), 64'd1);
        foreach (vecs[i]) begin
            csr_mem[vecs[i].addr] = vecs[i].init;
            issue(vecs[i].f3, vecs[i].addr, vecs[i].rs1, vecs[i].idx, ok);
            wcyc = 0; rcyc = 0; wd = '0; wa = '0; rdata = '0; ill = 1'b0;
            // k counts cycles after the accepting edge; first negedge is T+1
            for (int k = 1; k <= 8 && rcyc == 0; k++) begin
                if (k > 1) @(negedge clk);
                #1;
                if (o_csr_valid) begin
                    if (wcyc == 0) wcyc = k;
                    wd = o_csr_wd; wa = o_csr_wa;
                end
                if (o_resp_valid) begin
                    rcyc = k; rdata = o_resp_rdata; ill = o_resp_illegal;
                end
            end
            if (wcyc != 0) csr_mem[wa] = wd;
            chk($sformatf("v%0d_wcyc", i), 64'(wcyc), vecs[i].wr ? 64'd2 : 64'd0);
            if (vecs[i].wr) begin
                chk($sformatf("v%0d_wd", i), wd, vecs[i].wd);
                chk($sformatf("v%0d_wa", i), 64'(wa), 64'(vecs[i].addr));
            end
            chk($sformatf("v%0d_rcyc", i), 64'(rcyc), 64'd3);
            chk($sformatf("v%0d_rdata", i), rdata, vecs[i].rdata);
            chk($sformatf("v%0d_ill", i), 64'(ill), 64'(vecs[i].ill));
            @(negedge clk);
            #1;
            chk($sformatf("v%0d_ready_after", i), 64'(o_req_ready), 64'd1);
            chk($sformatf("v%0d_resp_low", i), 64'(o_resp_valid), 64'd0);
        end
        // backpressure: response held stable while resp_ready is low
        csr_mem[12'h340] = 64'h22;
        i_resp_ready = 1'b0;
        issue(3'b001, 12'h340, 64'h11, 5'd1, ok);
        @(negedge clk); @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_valid", 64'(o_resp_valid), 64'd1);
            chk("bp_rdata", o_resp_rdata, 64'h22);
            chk("bp_ready", 64'(o_req_ready), 64'd0);
            @(negedge clk);
        end
        i_resp_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("bp_release_ready", 64'(o_req_ready), 64'd1);
        chk("bp_release_valid", 64'(o_resp_valid), 64'd0);
        // flush during the WRITE cycle
        issue(3'b001, 12'h340, 64'h33, 5'd1, ok);
        @(negedge clk);
        i_flush = 1'b1;
        #1;
        chk("fl_csr_valid", 64'(o_csr_valid), 64'd0);
        @(negedge clk);
        i_flush = 1'b0;
        #1;
        chk("fl_resp_valid", 64'(o_resp_valid), 64'd0);
        chk("fl_req_ready", 64'(o_req_ready), 64'd1);
        // reset asserted while in RESP
        csr_mem[12'h341] = 64'h55;
        i_resp_ready = 1'b0;
        issue(3'b010, 12'h341, 64'h1, 5'd1, ok);
        @(negedge clk); @(negedge clk);
        #1;
        chk("rr_in_resp", 64'(o_resp_valid), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk("rr_resp_valid", 64'(o_resp_valid), 64'd0);
        chk("rr_rdata", o_resp_rdata, 64'd0);
        chk("rr_wd", o_csr_wd, 64'd0);
        chk("rr_wa_ra", {40'd0, o_csr_wa, o_csr_ra}, 64'd0);
        chk("rr_req_ready", 64'(o_req_ready), 64'd0);
        reset = 1'b0; i_resp_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("rr_ready_after", 64'(o_req_ready), 64'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
